// File: rtl/ps2_key_events.sv
// PS/2 scan-code to lane-event converter: held bitmap, press pulses, timestamped event FIFO.
// Define PS2_KEY_RELEASE_EVENTS_EN to also queue release events for held lanes.
module ps2_key_events #(
   parameter int         FIFO_DEPTH = 8,
   parameter int         TICK_DIV   = 500000,
   parameter int         TS_W       = 12,
   parameter logic [7:0] KEY0_CODE  = 8'h1C,
   parameter logic [7:0] KEY1_CODE  = 8'h1B,
   parameter logic [7:0] KEY2_CODE  = 8'h23,
   parameter logic [7:0] KEY3_CODE  = 8'h2B
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    ps2_byte,
   input  logic                          ps2_valid,
   output logic [3:0]                    key_held,
   output logic [3:0]                    key_press,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [TS_W+2:0]               evt_data,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   input  logic                          clr_ovf
);

   // state    | meaning
   // ST_IDLE  | waiting for a make code or prefix
   // ST_EXT   | E0 seen, extended code follows
   // ST_BRK   | F0 seen, next byte is a break code
   // ST_EXT_BRK | E0 F0 seen, next byte discarded

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = TS_W + 3;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   state_t          state;
   logic            act_make;
   logic            act_brk;
   logic [1:0]      act_lane;
   logic            lk_hit;
   logic [1:0]      lk_lane;

   logic [PW-1:0]   tick_cnt;
   logic [TS_W-1:0] ts;

   logic            push_req;
   logic [DW-1:0]   push_word;
   logic            do_pop;
   logic            do_wr;
   logic            drop;
   logic            full;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [DW-1:0]   mem [FIFO_DEPTH];

   always_comb begin
      lk_hit  = 1'b1;
      lk_lane = 2'd0;
      if (ps2_byte == KEY0_CODE)      lk_lane = 2'd0;
      else if (ps2_byte == KEY1_CODE) lk_lane = 2'd1;
      else if (ps2_byte == KEY2_CODE) lk_lane = 2'd2;
      else if (ps2_byte == KEY3_CODE) lk_lane = 2'd3;
      else                            lk_hit  = 1'b0;
   end

   // Parser registers a decoded make/break action; it is applied one edge later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         act_make <= 1'b0;
         act_brk  <= 1'b0;
         act_lane <= 2'd0;
      end else begin
         act_make <= 1'b0;
         act_brk  <= 1'b0;
         if (ps2_valid) begin
            case (state)
               ST_IDLE: begin
                  if (ps2_byte == CODE_EXT)      state <= ST_EXT;
                  else if (ps2_byte == CODE_BRK) state <= ST_BRK;
                  else begin
                     act_make <= lk_hit;
                     act_lane <= lk_lane;
                  end
               end
               ST_EXT: begin
                  state <= (ps2_byte == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
               end
               ST_BRK: begin
                  act_brk  <= lk_hit;
                  act_lane <= lk_lane;
                  state    <= ST_IDLE;
               end
               ST_EXT_BRK: state <= ST_IDLE;
               default:    state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         ts       <= '0;
      end else if (tick_cnt == PW'(TICK_DIV - 1)) begin
         tick_cnt <= '0;
         ts       <= ts + 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_comb begin
      push_req  = 1'b0;
      push_word = '0;
      if (act_make && !key_held[act_lane]) begin
         push_req  = 1'b1;
         push_word = {1'b0, act_lane, ts};
      end
`ifdef PS2_KEY_RELEASE_EVENTS_EN
      if (act_brk && key_held[act_lane]) begin
         push_req  = 1'b1;
         push_word = {1'b1, act_lane, ts};
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_held  <= 4'b0000;
         key_press <= 4'b0000;
      end else begin
         key_press <= 4'b0000;
         if (act_make && !key_held[act_lane]) begin
            key_held[act_lane]  <= 1'b1;
            key_press[act_lane] <= 1'b1;
         end
         if (act_brk) key_held[act_lane] <= 1'b0;
      end
   end

   // A push into a full FIFO still succeeds when the head leaves in the same cycle.
   assign evt_valid = (evt_count != '0);
   assign full      = (evt_count == CW'(FIFO_DEPTH));
   assign do_pop    = evt_valid && evt_ready;
   assign do_wr     = push_req && (!full || do_pop);
   assign drop      = push_req && full && !do_pop;
   assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !do_pop)      evt_count <= evt_count + 1'b1;
         else if (!do_wr && do_pop) evt_count <= evt_count - 1'b1;
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_key_events.sv
// Randomized bench for ps2_key_events against a byte-stream/queue reference model.
module tb_ps2_key_events;

   localparam int DEPTH = 8;
   localparam int DIV   = 4;
   localparam int TSW   = 3;
   localparam int DW    = TSW + 3;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [7:0]                ps2_byte = 8'h00;
   logic                      ps2_valid = 1'b0;
   logic [3:0]                key_held;
   logic [3:0]                key_press;
   logic                      evt_valid;
   logic                      evt_ready = 1'b0;
   logic [DW-1:0]             evt_data;
   logic [$clog2(DEPTH):0]    evt_count;
   logic                      overflow;
   logic                      clr_ovf = 1'b0;

   always #5 clk = ~clk;

   ps2_key_events #(
      .FIFO_DEPTH(DEPTH), .TICK_DIV(DIV), .TS_W(TSW)
   ) dut (
      .clk(clk), .reset(reset), .ps2_byte(ps2_byte), .ps2_valid(ps2_valid),
      .key_held(key_held), .key_press(key_press), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_data(evt_data), .evt_count(evt_count),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: byte-prefix flags, lane bitmap, event queue, edge count
   logic [3:0]    m_held;
   logic [3:0]    m_press;
   logic          m_ovf;
   logic [DW-1:0] m_q[$];
   bit            m_ext, m_brk;
   int            pend_kind;
   int            pend_lane;
   int            m_edges;

   function automatic int lane_of(input logic [7:0] b);
      logic [7:0] codes [4];
      codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
      for (int i = 0; i < 4; i++) if (codes[i] == b) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_held = '0; m_press = '0; m_ovf = 1'b0; m_q.delete();
      m_ext = 0; m_brk = 0; pend_kind = 0; pend_lane = 0; m_edges = 0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
      int stamp, sz, ln;
      bit push, pop, drop;
      logic [DW-1:0] w;
      stamp = (m_edges / DIV) % (1 << TSW);
      m_edges++;
      m_press = '0;
      push = 0;
      w = '0;
      if (pend_kind == 1 && !m_held[pend_lane]) begin
         m_held[pend_lane] = 1'b1;
         m_press[pend_lane] = 1'b1;
         push = 1;
         w = {1'b0, 2'(pend_lane), TSW'(stamp)};
      end
      if (pend_kind == 2 && m_held[pend_lane]) begin
         m_held[pend_lane] = 1'b0;
`ifdef PS2_KEY_RELEASE_EVENTS_EN
         push = 1;
         w = {1'b1, 2'(pend_lane), TSW'(stamp)};
`endif
      end
      sz = m_q.size();
      pop = (sz > 0) && rdy;
      drop = 0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (sz == DEPTH && !pop) drop = 1;
         else m_q.push_back(w);
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      pend_kind = 0;
      if (v) begin
         ln = lane_of(b);
         if (!m_ext && !m_brk) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (ln >= 0) begin pend_kind = 1; pend_lane = ln; end
         end else if (m_ext && !m_brk) begin
            if (b == 8'hF0) m_brk = 1;
            else m_ext = 0;
         end else if (m_brk && !m_ext) begin
            if (ln >= 0) begin pend_kind = 2; pend_lane = ln; end
            m_brk = 0;
         end else begin
            m_ext = 0; m_brk = 0;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".held"},  32'(key_held),  32'(m_held));
      check({tag, ".press"}, 32'(key_press), 32'(m_press));
      check({tag, ".count"}, 32'(evt_count), 32'(m_q.size()));
      check({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
      check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
      check({tag, ".data"},  32'(evt_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
   endtask

   // starts and ends just after a falling edge
   task automatic step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
      ps2_valid = v; ps2_byte = b; evt_ready = rdy; clr_ovf = clr;
      @(posedge clk);
      model_edge(v, b, rdy, clr);
      #1;
      compare_all("step");
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ps2_valid = 1'b0; ps2_byte = 8'h00; evt_ready = 1'b0; clr_ovf = 1'b0;
      model_reset();
      #1;
      compare_all("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [DW-1:0] last_head;

   task automatic drain();
      int guard;
      guard = 0;
      while (m_q.size() > 0 && guard < 40) begin
         last_head = evt_data;
         step(1'b0, 8'h00, 1'b1, 1'b0);
         guard++;
      end
      check("drain_done", 32'(m_q.size()), 32'd0);
   endtask

   logic [7:0] codes_tb [4];

   initial begin
      codes_tb = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
      @(negedge clk);
      do_reset();

      // make, then break on lane 0
      send(8'h1C); idle(2);
      send(8'hF0); send(8'h1C); idle(2);
      check("basic_held", 32'(key_held), 32'h0);
`ifdef PS2_KEY_RELEASE_EVENTS_EN
      check("basic_count", 32'(evt_count), 32'd2);
`else
      check("basic_count", 32'(evt_count), 32'd1);
`endif
      drain();

      // typematic repeats back-to-back
      for (int i = 0; i < 5; i++) send(8'h1B);
      idle(2);
      check("typ_held", 32'(key_held), 32'b0010);
      check("typ_count", 32'(evt_count), 32'd1);
      send(8'hF0); send(8'h1B); idle(1);
      drain();

      // extended codes never touch lanes
      send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h23); idle(2);
      check("ext_held", 32'(key_held), 32'h0);
      check("ext_count", 32'(evt_count), 32'd0);
      send(8'h23); idle(1);
      check("ext_idle_after", 32'(key_held), 32'b0100);
      send(8'hF0); send(8'h23); idle(1);
      drain();

      // 9 presses into an 8-deep FIFO with no consumer
      for (int i = 0; i < 9; i++) begin
         send(codes_tb[i % 4]); send(8'hF0); send(codes_tb[i % 4]);
      end
      idle(2);
      check("ovf_count", 32'(evt_count), 32'd8);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_head_lane", 32'(evt_data[TSW+1:TSW]), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", 32'(overflow), 32'd0);

      // push into full FIFO with a same-cycle pop
      send(8'h1B);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("fullpop_count", 32'(evt_count), 32'd8);
      check("fullpop_ovf", 32'(overflow), 32'd0);
      drain();
      check("fullpop_last", 32'(last_head), 32'({1'b0, 2'd1, m_q.size() == 0 ? last_head[TSW-1:0] : 3'd0}));
      check("fullpop_last_lane", 32'(last_head[TSW+1:TSW]), 32'd1);
      send(8'hF0); send(8'h1B); idle(1);
      drain();

      // timestamp wrap: 40 idle cycles after reset, then press lane 3
      do_reset();
      idle(40);
      send(8'h2B); idle(1);
      check("ts_word", 32'(evt_data), 32'({1'b0, 2'd3, 3'd2}));

      // reset mid-break: next byte is a fresh make
      send(8'hF0);
      do_reset();
      send(8'h23);
      idle(1);
      check("rst_mid_held", 32'(key_held), 32'b0100);
      idle(1);

      // randomized byte stream with random consumer and overflow clears
      for (int i = 0; i < 400; i++) begin
         logic [7:0] b;
         int sel;
         sel = $urandom_range(0, 7);
         case (sel)
            4: b = 8'hE0;
            5: b = 8'hF0;
            6: b = 8'($urandom);
            default: b = codes_tb[$urandom_range(0, 3)];
         endcase
         step(($urandom % 3) == 0, b, ($urandom % 4) == 0, ($urandom % 16) == 0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_key_events.md
Name: ps2_key_events

Overview:
- Converts the raw PS/2 scan-code byte stream from the keyboard receiver into lane-level key events for the four game keys.
- Maintains the held-key bitmap, one-cycle press pulses, and a timestamped event FIFO.
- Sits between the PS/2 receiver and the game control/datapath (secondlevel), which reads one event at a time via valid/ready to judge hit timing.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..32.
- TICK_DIV, 500000, clk cycles per timestamp tick (10 ms at 50 MHz).
- TS_W, 12, timestamp width in bits; wraps modulo 2^TS_W.
- KEY0_CODE, 8'h1C, make code for lane 0 (A).
- KEY1_CODE, 8'h1B, make code for lane 1 (S).
- KEY2_CODE, 8'h23, make code for lane 2 (D).
- KEY3_CODE, 8'h2B, make code for lane 3 (F).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- ps2_byte  input  8  received scan-code byte.
- ps2_valid  input  1  one-cycle strobe: ps2_byte is new.
- key_held  output  4  current held state per lane.
- key_press  output  4  one-cycle pulse per lane on a new press.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer pops the head when evt_valid && evt_ready.
- evt_data  output  TS_W+3  {release_flag, lane[1:0], timestamp[TS_W-1:0]}.
- evt_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  output  1  sticky flag: an event was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync-released logic) sets:
  - parser to IDLE;
  - key_held, key_press, evt_count, overflow, and the tick prescaler to 0;
  - timestamp counter to 0, FIFO pointers to 0;
  - evt_valid=0, evt_data=0.
- Timestamp:
  - The prescaler counts 0..TICK_DIV-1; on the terminal count the timestamp increments.
  - The timestamp wraps 2^TS_W-1 -> 0.
- Parser FSM (advances only on ps2_valid):
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Any other byte is a make code; the lookup is applied, then return to IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - Else -> IDLE, byte discarded.
  - BRK: byte is a break code; lookup is applied, then -> IDLE.
  - EXT_BRK: byte discarded -> IDLE.
  - Extended codes never affect lanes.
- Make on lane i:
  - If key_held[i]==0: set key_held[i], pulse key_press[i] for exactly one cycle, push event {0,i,ts}.
  - If already held (typematic repeat): no pulse, no push.
- Break on lane i:
  - Clear key_held[i].
  - No push (see optional feature).
  - A break for a key not held is ignored.
- Unmapped codes are ignored in all states.
- Latency:
  - ps2_valid on the final byte at edge N -> key_held/key_press updated after edge N+1.
  - The pushed entry is visible at the head (evt_valid=1) after edge N+1 if the FIFO was empty (first-word fall-through).
- FIFO:
  - Pop when evt_valid && evt_ready.
  - Push when full without a same-cycle pop: event dropped, overflow<=1, contents unchanged.
  - Push when full with a same-cycle pop: both occur, evt_count unchanged.
  - Pop when empty: no effect.
  - Simultaneous push and pop when non-empty: evt_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Set on a dropped event; cleared by clr_ovf.
  - If a set and clr_ovf occur in the same cycle, set wins.
- ps2_valid held high for consecutive cycles: each cycle is a separate byte.
- Reset asserted mid-sequence (e.g., after F0): the parser returns to IDLE and the next byte is treated as a fresh code.

Optional Feature:
- Macro: PS2_KEY_RELEASE_EVENTS_EN.
- Defined: a break on a held lane also pushes {1,i,ts}, with the same overflow rules as press events.
- Undefined: release_flag is always 0; only press events are queued.

Test Plan:
- Reset, then bytes 1C, F0, 1C with ps2_valid pulses:
  - key_held=0001 after the first byte, one key_press=0001 pulse;
  - FIFO holds one entry {0,00,ts}; key_held=0000 after F0 1C;
  - evt_count=1 without the macro, 2 with it.
- Repeat 1B five times (typematic):
  - exactly one key_press=0010 pulse, evt_count=1, key_held=0010.
- Bytes E0 1C, then E0 F0 23:
  - key_held stays 0000, no pulses, evt_count=0, parser back in IDLE.
- With evt_ready=0, press/release lanes alternately to generate 9 press events, FIFO_DEPTH=8:
  - evt_count=8, overflow=1;
  - the head is the first event (lane 0); the 9th event is absent;
  - clr_ovf pulse -> overflow=0.
- Full FIFO, evt_ready=1 in the same cycle a new press arrives:
  - evt_count stays 8, overflow stays 0;
  - the new event appears as the last entry after 8 pops.
- With TICK_DIV=4 and TS_W=3, hold idle for 40 cycles, then press 2B:
  - evt_data timestamp = 10 mod 8 = 2, lane=11, release_flag=0.
- Reset asserted after byte F0, then byte 23 after release:
  - 23 is treated as a make: key_held=0100 and one key_press pulse.
